macro_pattern_gen: RTL

Parametrised, sequenced successor to the per-macro IO stub used in the mini-SoC array simulations. Each instance drives its east, west and north IO buses with one of four patterns:
- a static one-hot identity pattern;
- a walking one;
- a binary count;
- tri-state off.

It is started and stopped by a simple control handshake and runs for a programmable number of steps at a programmable rate. An optional loopback checker on the north bus counts mismatches for array-level connectivity tests.

---
 rtl/macro_pattern_gen.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/macro_pattern_gen.sv
// macro_pattern_gen: sequenced IO pattern driver for one macro of the array.
// Drives east/west/north buses with STATIC one-hot, WALK one-hot, binary
// COUNT or OFF patterns. A run is started and stopped by a control handshake
// and lasts a programmable number of steps at a programmable step rate.
//
// Optional feature macro: MACRO_PATGEN_CHECK_EN enables the north loopback
// checker. When it is not defined, err_cnt_o is tied to 0 and IO_north_i is
// unused.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   mode_i                 0 STATIC, 1 WALK, 2 COUNT, 3 OFF (sampled on start)
//   start_i, stop_i        run start request / abort request
//   div_i                  step period minus one (sampled on start)
//   len_i                  steps to run, 0 = free-run (sampled on start)
//   busy_o, done_o         running flag / completion pulse
//   IO_<side>_o / _oe      pattern data / output enable per side
//   IO_north_i             north loopback input for the checker
//   err_cnt_o              saturating loopback mismatch count
module macro_pattern_gen #(
   parameter int unsigned NUMBER  = 0,
   parameter int unsigned EAST_W  = 14,
   parameter int unsigned WEST_W  = 14,
   parameter int unsigned NORTH_W = 10,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned LEN_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [1:0]         mode_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [DIV_W-1:0]   div_i,
   input  logic [LEN_W-1:0]   len_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [EAST_W-1:0]  IO_east_o,
   output logic [EAST_W-1:0]  IO_east_oe,
   output logic [WEST_W-1:0]  IO_west_o,
   output logic [WEST_W-1:0]  IO_west_oe,
   output logic [NORTH_W-1:0] IO_north_o,
   output logic [NORTH_W-1:0] IO_north_oe,
   input  logic [NORTH_W-1:0] IO_north_i,
   output logic [7:0]         err_cnt_o
);

   localparam int unsigned EPW = $clog2(EAST_W);
   localparam int unsigned WPW = $clog2(WEST_W);
   localparam int unsigned NPW = $clog2(NORTH_W);

   // Starting one-hot positions (also the STATIC positions)
   localparam logic [EPW-1:0] EPOS0 = EPW'(NUMBER % EAST_W);
   localparam logic [WPW-1:0] WPOS0 = WPW'(NUMBER % WEST_W);
   localparam logic [NPW-1:0] NPOS0 = NPW'(NUMBER % NORTH_W);

   localparam logic [EAST_W-1:0]  EAST_STATIC  = EAST_W'(1) << EPOS0;
   localparam logic [WEST_W-1:0]  WEST_STATIC  = WEST_W'(1) << WPOS0;
   localparam logic [NORTH_W-1:0] NORTH_STATIC = NORTH_W'(1) << NPOS0;

   localparam logic [1:0] M_STATIC = 2'd0;
   localparam logic [1:0] M_WALK   = 2'd1;
   localparam logic [1:0] M_COUNT  = 2'd2;
   localparam logic [1:0] M_OFF    = 2'd3;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_mode;
   logic [DIV_W-1:0]   r_div, r_presc;
   logic [LEN_W-1:0]   r_len, r_step;
   logic [EPW-1:0]     r_pos_e;
   logic [WPW-1:0]     r_pos_w;
   logic [NPW-1:0]     r_pos_n;
   logic               r_busy, r_done;
   logic [EAST_W-1:0]  r_east, r_east_oe;
   logic [WEST_W-1:0]  r_west, r_west_oe;
   logic [NORTH_W-1:0] r_north, r_north_oe;

   logic               w_start, w_adv, w_final, w_tick, w_oe_on;
   logic [LEN_W-1:0]   w_step_inc, w_step_sel;
   logic [1:0]         w_mode_sel;
   logic [EPW-1:0]     w_pos_e_sel;
   logic [WPW-1:0]     w_pos_w_sel;
   logic [NPW-1:0]     w_pos_n_sel;
   logic [EAST_W-1:0]  w_east_pat;
   logic [WEST_W-1:0]  w_west_pat;
   logic [NORTH_W-1:0] w_north_pat;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and run control; stop outranks a coincident final tick
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_adv       = 1'b0;
      w_final     = 1'b0;
      w_tick      = (r_presc == r_div);
      w_step_inc  = r_step + LEN_W'(1);
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_start     = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (stop_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_tick) begin
               w_adv = 1'b1;
               if ((r_len != '0) && (w_step_inc == r_len)) begin
                  w_final     = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pattern for the value about to be loaded: step 0 on start, else step+1
   always_comb begin
      w_mode_sel  = w_start ? mode_i : r_mode;
      w_step_sel  = w_start ? '0 : w_step_inc;
      w_pos_e_sel = w_start ? EPOS0 :
                    ((r_pos_e == EPW'(EAST_W - 1)) ? '0 : r_pos_e + EPW'(1));
      w_pos_w_sel = w_start ? WPOS0 :
                    ((r_pos_w == WPW'(WEST_W - 1)) ? '0 : r_pos_w + WPW'(1));
      w_pos_n_sel = w_start ? NPOS0 :
                    ((r_pos_n == NPW'(NORTH_W - 1)) ? '0 : r_pos_n + NPW'(1));
      w_oe_on     = (w_mode_sel != M_OFF);
      w_east_pat  = '0;
      w_west_pat  = '0;
      w_north_pat = '0;
      case (w_mode_sel)
         M_STATIC: begin
            w_east_pat  = EAST_STATIC;
            w_west_pat  = WEST_STATIC;
            w_north_pat = NORTH_STATIC;
         end
         M_WALK: begin
            w_east_pat  = EAST_W'(1)  << w_pos_e_sel;
            w_west_pat  = WEST_W'(1)  << w_pos_w_sel;
            w_north_pat = NORTH_W'(1) << w_pos_n_sel;
         end
         M_COUNT: begin
            w_east_pat  = EAST_W'(NUMBER)  + EAST_W'(w_step_sel);
            w_west_pat  = WEST_W'(NUMBER)  + WEST_W'(w_step_sel);
            w_north_pat = NORTH_W'(NUMBER) + NORTH_W'(w_step_sel);
         end
         default: ;
      endcase
   end

   // Datapath: latched run parameters, step/prescaler, registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mode     <= M_STATIC;
         r_div      <= '0;
         r_len      <= '0;
         r_presc    <= '0;
         r_step     <= '0;
         r_pos_e    <= EPOS0;
         r_pos_w    <= WPOS0;
         r_pos_n    <= NPOS0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_east     <= EAST_STATIC;
         r_west     <= WEST_STATIC;
         r_north    <= NORTH_STATIC;
         r_east_oe  <= '1;
         r_west_oe  <= '1;
         r_north_oe <= '1;
      end else begin
         r_done <= w_final;
         r_busy <= (w_state_nxt == S_RUN);
         if (w_start) begin
            r_mode  <= mode_i;
            r_div   <= div_i;
            r_len   <= len_i;
            r_presc <= '0;
         end else if (r_state == S_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
         end
         if (w_start || w_adv) begin
            r_step     <= w_step_sel;
            r_pos_e    <= w_pos_e_sel;
            r_pos_w    <= w_pos_w_sel;
            r_pos_n    <= w_pos_n_sel;
            r_east     <= w_east_pat;
            r_west     <= w_west_pat;
            r_north    <= w_north_pat;
            r_east_oe  <= {EAST_W{w_oe_on}};
            r_west_oe  <= {WEST_W{w_oe_on}};
            r_north_oe <= {NORTH_W{w_oe_on}};
         end
      end
   end

`ifdef MACRO_PATGEN_CHECK_EN
   logic [7:0] r_err;

   // Loopback is combinational, so IO_north_i reflects this cycle's r_north
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                           r_err <= '0;
      else if (w_start)                                      r_err <= '0;
      else if ((r_state == S_RUN) && (IO_north_i != r_north)
               && (r_err != 8'hFF))                          r_err <= r_err + 8'd1;
   end

   assign err_cnt_o = r_err;
`else
   logic w_unused_north;
   assign w_unused_north = ^IO_north_i;
   assign err_cnt_o      = 8'h00;
`endif

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign IO_east_o   = r_east;
   assign IO_east_oe  = r_east_oe;
   assign IO_west_o   = r_west;
   assign IO_west_oe  = r_west_oe;
   assign IO_north_o  = r_north;
   assign IO_north_oe = r_north_oe;

endmodule
